// File: rtl/uart_frame_parser.sv
// Byte-stream framer: hunts for SYNC, parses CMD/LEN/PAYLOAD/CSUM, checks the XOR
// checksum and holds each good frame for the consumer behind a valid/ack handshake.
//
// state   | meaning
// HUNT    | discarding bytes until SYNC_BYTE arrives
// CMD     | waiting for the command byte
// LEN     | waiting for the payload length byte
// PAYLOAD | storing payload bytes into the buffer
// CSUM    | waiting for the XOR checksum byte
// HOLD    | good frame held, incoming bytes dropped until ack
module uart_frame_parser #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         MAX_LEN        = 16,
    parameter int         TIMEOUT_CYCLES = 72_000,
    localparam int        LEN_W          = $clog2(MAX_LEN + 1),
    localparam int        ADDR_W         = $clog2(MAX_LEN),
    localparam int        IDLE_W         = $clog2(TIMEOUT_CYCLES)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              rx_error,
    output logic              frame_valid,
    output logic [7:0]        frame_cmd,
    output logic [LEN_W-1:0]  frame_len,
    input  logic              frame_ack,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    output logic              busy,
    output logic [7:0]        csum_err_cnt,
    output logic [7:0]        drop_cnt,
    output logic [7:0]        timeout_cnt
);

    typedef enum logic [2:0] {
        HUNT, CMD, LEN, PAYLOAD, CSUM, HOLD
    } state_t;

    state_t            state, state_next;
    logic [7:0]        xor_acc;
    logic [ADDR_W-1:0] idx;
    logic [IDLE_W-1:0] idle;
    logic [7:0]        payload_buf [0:MAX_LEN-1];

    logic ev_csum_err, ev_drop, ev_timeout, buf_we, accept;
    logic last_byte;

    assign accept    = rx_valid && !rx_error;
    assign last_byte = (LEN_W'(idx) + LEN_W'(1)) == frame_len;

    function automatic logic [7:0] sat_inc(input logic [7:0] c, input logic ev);
        return (ev && c != 8'hFF) ? c + 8'd1 : c;
    endfunction

    always_comb begin
        state_next  = state;
        ev_csum_err = 1'b0;
        ev_drop     = 1'b0;
        ev_timeout  = 1'b0;
        buf_we      = 1'b0;
        case (state)
            HUNT: begin
                if (rx_valid && rx_data == SYNC_BYTE)
                    state_next = CMD;
            end
            HOLD: begin
                ev_drop = rx_valid;
                if (frame_ack)
                    state_next = HUNT;
            end
            default: begin
                if (rx_error) begin
                    state_next = HUNT;
                    ev_timeout = 1'b1;
                end else if (rx_valid) begin
                    case (state)
                        CMD: state_next = LEN;
                        LEN: begin
                            if (int'(rx_data) > MAX_LEN) begin
                                state_next  = HUNT;
                                ev_csum_err = 1'b1;
                            end else if (rx_data == 8'd0) begin
                                state_next = CSUM;
                            end else begin
                                state_next = PAYLOAD;
                            end
                        end
                        PAYLOAD: begin
                            buf_we = 1'b1;
                            if (last_byte)
                                state_next = CSUM;
                        end
                        CSUM: begin
                            if (rx_data == xor_acc) begin
                                state_next = HOLD;
                            end else begin
                                state_next  = HUNT;
                                ev_csum_err = 1'b1;
                            end
                        end
                        default: state_next = HUNT;
                    endcase
                end else if (idle == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
                    state_next = HUNT;
                    ev_timeout = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= HUNT;
            busy         <= 1'b0;
            frame_valid  <= 1'b0;
            frame_cmd    <= 8'd0;
            frame_len    <= '0;
            xor_acc      <= 8'd0;
            idx          <= '0;
            idle         <= '0;
            csum_err_cnt <= 8'd0;
            drop_cnt     <= 8'd0;
            timeout_cnt  <= 8'd0;
            rd_data      <= 8'd0;
        end else begin
            state       <= state_next;
            busy        <= state_next != HUNT;
            frame_valid <= state_next == HOLD;
            rd_data     <= payload_buf[rd_addr];

            if (accept) begin
                case (state)
                    CMD: begin
                        frame_cmd <= rx_data;
                        xor_acc   <= rx_data;
                    end
                    LEN: begin
                        frame_len <= LEN_W'(rx_data);
                        xor_acc   <= xor_acc ^ rx_data;
                        idx       <= '0;
                    end
                    PAYLOAD: begin
                        xor_acc <= xor_acc ^ rx_data;
                        idx     <= idx + ADDR_W'(1);
                    end
                    default: ;
                endcase
            end

            // idle only advances while a frame is in flight and nothing arrives
            if (rx_valid || state == HUNT || state == HOLD || state_next == HUNT)
                idle <= '0;
            else
                idle <= idle + IDLE_W'(1);

            csum_err_cnt <= sat_inc(csum_err_cnt, ev_csum_err);
            drop_cnt     <= sat_inc(drop_cnt, ev_drop);
            timeout_cnt  <= sat_inc(timeout_cnt, ev_timeout);
        end
    end

    always_ff @(posedge clk) begin
        if (buf_we)
            payload_buf[idx] <= rx_data;
    end

endmodule
